// File: rtl/run_ctrl_pkg.sv
// Shared types and constants for the CPU run controller: FSM state encoding and
// the default end-of-program instruction word.
package run_ctrl_pkg;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_RST,
        ST_RUN,
        ST_DONE
    } state_t;

    // beq $0,$0,-1: a core spinning on itself has finished its program
    localparam logic [31:0] HALT_WORD_DEFAULT = 32'h1000ffff;

    localparam int RST_CNT_W = 8;

endpackage

// File: rtl/run_ctrl_halt_detect.sv
// Per-core halt detector: compares the core's current instruction against the
// halt word and keeps a sticky flag until the next run's reset phase.
module halt_detect
    import run_ctrl_pkg::*;
#(
    parameter logic [31:0] HALT_WORD = HALT_WORD_DEFAULT
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        clear,
    input  logic        enable,
    input  logic [31:0] instr,
    output logic        halted,
    output logic        halted_nxt
);

    // Look-ahead value lets the controller see a core's final halt this cycle
    assign halted_nxt = halted | (enable && (instr == HALT_WORD));

    always_ff @(posedge clk) begin
        if (reset || clear) begin
            halted <= 1'b0;
        end else begin
            halted <= halted_nxt;
        end
    end

endmodule

// File: rtl/run_ctrl.sv
// Run controller: holds the cores in reset, releases them for a bounded run and
// reports completion once every core has reached its halt instruction.
module run_ctrl
    import run_ctrl_pkg::*;
#(
    parameter int          NCORE      = 1,
    parameter int          RST_CYCLES = 2,
    parameter int          MAX_CYCLES = 10000,
    parameter int          CNT_W      = 32,
    parameter logic [31:0] HALT_WORD  = HALT_WORD_DEFAULT
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start,
    input  logic [32*NCORE-1:0]   instr_i,
    output logic                  cpu_reset,
    output logic                  running,
    output logic                  done,
    output logic                  timeout,
    output logic [NCORE-1:0]      halted,
    output logic [CNT_W-1:0]      cycle_count
);

    state_t               state;
    state_t               state_nxt;
    logic [RST_CNT_W-1:0] rst_cnt;
    logic [NCORE-1:0]     halted_nxt;
    logic                 in_run;
    logic                 all_halted;
    logic                 budget_out;
    logic                 rst_entry;

    assign in_run     = (state == ST_RUN);
    assign all_halted = &halted_nxt;
    // A final halt in the last budget cycle counts as success, not timeout
    assign budget_out = in_run && !all_halted &&
                        (cycle_count == CNT_W'(MAX_CYCLES - 1));
    assign rst_entry  = (state_nxt == ST_RST) && (state != ST_RST);

    for (genvar k = 0; k < NCORE; k++) begin : g_core
        halt_detect #(
            .HALT_WORD (HALT_WORD)
        ) u_halt_detect (
            .clk        (clk),
            .reset      (reset),
            .clear      (rst_entry),
            .enable     (in_run),
            .instr      (instr_i[32*k +: 32]),
            .halted     (halted[k]),
            .halted_nxt (halted_nxt[k])
        );
    end

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE: if (start) state_nxt = ST_RST;
            ST_RST:  if (rst_cnt == RST_CNT_W'(RST_CYCLES - 1)) state_nxt = ST_RUN;
            ST_RUN:  if (all_halted || budget_out) state_nxt = ST_DONE;
            ST_DONE: if (start) state_nxt = ST_RST;
            default: state_nxt = ST_IDLE;
        endcase
    end

    // Status outputs are registered from the next state so they line up with it
    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= ST_IDLE;
            rst_cnt     <= '0;
            cpu_reset   <= 1'b1;
            running     <= 1'b0;
            done        <= 1'b0;
            timeout     <= 1'b0;
            cycle_count <= '0;
        end else begin
            state     <= state_nxt;
            cpu_reset <= (state_nxt == ST_IDLE) || (state_nxt == ST_RST);
            running   <= (state_nxt == ST_RUN);
            done      <= (state_nxt == ST_DONE);
            rst_cnt   <= ((state == ST_RST) && (state_nxt == ST_RST)) ?
                         rst_cnt + RST_CNT_W'(1) : '0;
            if (rst_entry) begin
                timeout     <= 1'b0;
                cycle_count <= '0;
            end else if (in_run) begin
                if (budget_out) begin
                    timeout <= 1'b1;
                end else begin
                    cycle_count <= cycle_count + CNT_W'(1);
                end
            end
        end
    end

endmodule

// File: tb/tb_run_ctrl.sv
// Randomized self-checking bench for run_ctrl with three cores and a short
// cycle budget; expected results come from per-core halt schedules.
module tb_run_ctrl;

   localparam int          NCORE      = 3;
   localparam int          RST_CYCLES = 2;
   localparam int          MAX_CYCLES = 20;
   localparam int          CNT_W      = 16;
   localparam logic [31:0] HALT       = 32'h1000ffff;

   logic                 clk = 1'b0;
   logic                 reset;
   logic                 start;
   logic [32*NCORE-1:0]  instr_i;
   logic                 cpu_reset;
   logic                 running;
   logic                 done;
   logic                 timeout;
   logic [NCORE-1:0]     halted;
   logic [CNT_W-1:0]     cycle_count;

   int checks = 0;
   int errors = 0;

   run_ctrl #(
      .NCORE      (NCORE),
      .RST_CYCLES (RST_CYCLES),
      .MAX_CYCLES (MAX_CYCLES),
      .CNT_W      (CNT_W),
      .HALT_WORD  (HALT)
   ) dut (
      .clk         (clk),
      .reset       (reset),
      .start       (start),
      .instr_i     (instr_i),
      .cpu_reset   (cpu_reset),
      .running     (running),
      .done        (done),
      .timeout     (timeout),
      .halted      (halted),
      .cycle_count (cycle_count)
   );

   always #5 clk = ~clk;

   function automatic logic [31:0] rand_word();
      logic [31:0] w;
      w = $urandom;
      if (w == HALT) w = w ^ 32'h1;
      return w;
   endfunction

   task automatic randomize_instr();
      for (int k = 0; k < NCORE; k++) instr_i[32*k +: 32] = rand_word();
   endtask

   // Full run: h[k] is the RUN cycle at which core k shows the halt word (-1 = never)
   task automatic do_run(input int ha, input int hb, input int hc, input string name);
      int h[NCORE];
      int c;
      int rst_seen;
      int fin;
      int last;
      logic             exp_to;
      logic [CNT_W-1:0] exp_cnt;
      logic [NCORE-1:0] exp_halt;
      h[0] = ha; h[1] = hb; h[2] = hc;

      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      rst_seen = 0;
      while (!running && rst_seen < 10) begin
         checks++;
         if (cpu_reset !== 1'b1 || done !== 1'b0 || halted !== '0 ||
             cycle_count !== '0 || timeout !== 1'b0) begin
            errors++;
            $display("[TB] FAIL %s rst_phase cpu_reset=%b done=%b halted=%b count=%0d timeout=%b expected 1 0 000 0 0",
                     name, cpu_reset, done, halted, cycle_count, timeout);
         end
         rst_seen++;
         start = 1'($urandom_range(0, 1));
         @(negedge clk);
      end
      start = 1'b0;
      checks++;
      if (rst_seen != RST_CYCLES) begin
         errors++;
         $display("[TB] FAIL %s rst_length got %0d expected %0d", name, rst_seen, RST_CYCLES);
      end

      c = 0;
      while (running && c < 40) begin
         exp_halt = '0;
         for (int k = 0; k < NCORE; k++)
            exp_halt[k] = (h[k] >= 0) && (h[k] < c);
         checks++;
         if (cycle_count !== CNT_W'(c) || halted !== exp_halt ||
             cpu_reset !== 1'b0 || done !== 1'b0) begin
            errors++;
            $display("[TB] FAIL %s run_cycle%0d count=%0d halted=%b cpu_reset=%b done=%b expected %0d %b 0 0",
                     name, c, cycle_count, halted, cpu_reset, done, c, exp_halt);
         end
         for (int k = 0; k < NCORE; k++)
            instr_i[32*k +: 32] = (c == h[k]) ? HALT : rand_word();
         start = 1'($urandom_range(0, 1));
         c++;
         @(negedge clk);
      end
      start = 1'b0;
      randomize_instr();

      fin = 0;
      for (int k = 0; k < NCORE; k++) begin
         if (h[k] < 0) fin = 1000;
         else if (h[k] > fin) fin = h[k];
      end
      if (fin <= MAX_CYCLES - 1) begin
         exp_to  = 1'b0;
         exp_cnt = CNT_W'(fin + 1);
         last    = fin;
      end else begin
         exp_to  = 1'b1;
         exp_cnt = CNT_W'(MAX_CYCLES - 1);
         last    = MAX_CYCLES - 1;
      end
      exp_halt = '0;
      for (int k = 0; k < NCORE; k++)
         exp_halt[k] = (h[k] >= 0) && (h[k] <= last);

      checks++;
      if (c != last + 1) begin
         errors++;
         $display("[TB] FAIL %s run_length got %0d expected %0d", name, c, last + 1);
      end
      for (int i = 0; i < 2; i++) begin
         checks++;
         if (done !== 1'b1 || running !== 1'b0 || cpu_reset !== 1'b0 ||
             timeout !== exp_to || cycle_count !== exp_cnt || halted !== exp_halt) begin
            errors++;
            $display("[TB] FAIL %s done_state%0d done=%b running=%b cpu_reset=%b timeout=%b count=%0d halted=%b expected 1 0 0 %b %0d %b",
                     name, i, done, running, cpu_reset, timeout, cycle_count, halted,
                     exp_to, exp_cnt, exp_halt);
         end
         randomize_instr();
         @(negedge clk);
      end
   endtask

   task automatic test_reset();
      reset = 1'b1;
      start = 1'b0;
      randomize_instr();
      @(negedge clk);
      @(negedge clk);
      checks++;
      if (cpu_reset !== 1'b1 || running !== 1'b0 || done !== 1'b0 ||
          timeout !== 1'b0 || halted !== '0 || cycle_count !== '0) begin
         errors++;
         $display("[TB] FAIL reset_values cpu_reset=%b running=%b done=%b timeout=%b halted=%b count=%0d expected 1 0 0 0 000 0",
                  cpu_reset, running, done, timeout, halted, cycle_count);
      end
      reset = 1'b0;
      for (int i = 0; i < 4; i++) @(negedge clk);
      checks++;
      if (cpu_reset !== 1'b1 || running !== 1'b0 || done !== 1'b0) begin
         errors++;
         $display("[TB] FAIL idle_hold cpu_reset=%b running=%b done=%b expected 1 0 0",
                  cpu_reset, running, done);
      end
   endtask

   task automatic test_single_halt();
      do_run(5, 2, 0, "single_halt");
   endtask

   task automatic test_timeout();
      do_run(-1, -1, -1, "timeout_none");
      do_run(3, -1, 10, "timeout_partial");
   endtask

   task automatic test_multi_halt();
      do_run(3, 9, 7, "multi_halt");
   endtask

   task automatic test_halt_at_budget();
      do_run(19, 4, 19, "halt_at_budget");
      do_run(-1, 19, 0, "halt_miss_budget");
   endtask

   task automatic test_back_to_back();
      int r;
      int hv[NCORE];
      for (int n = 0; n < 8; n++) begin
         for (int k = 0; k < NCORE; k++) begin
            r = $urandom_range(0, 24);
            hv[k] = (r > 21) ? -1 : r;
         end
         do_run(hv[0], hv[1], hv[2], "random_run");
      end
   endtask

   task automatic test_reset_mid_run();
      int c;
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      c = 0;
      while (!running && c < 10) begin
         c++;
         @(negedge clk);
      end
      c = 0;
      while (running && cycle_count != CNT_W'(4) && c < 10) begin
         instr_i[31:0] = (c == 1) ? HALT : rand_word();
         c++;
         @(negedge clk);
      end
      checks++;
      if (running !== 1'b1 || cycle_count !== CNT_W'(4) || halted !== 3'b001) begin
         errors++;
         $display("[TB] FAIL pre_reset running=%b count=%0d halted=%b expected 1 4 001",
                  running, cycle_count, halted);
      end
      reset = 1'b1;
      @(negedge clk);
      reset = 1'b0;
      checks++;
      if (cpu_reset !== 1'b1 || running !== 1'b0 || done !== 1'b0 ||
          halted !== '0 || cycle_count !== '0 || timeout !== 1'b0) begin
         errors++;
         $display("[TB] FAIL reset_mid_run cpu_reset=%b running=%b done=%b halted=%b count=%0d timeout=%b expected 1 0 0 000 0 0",
                  cpu_reset, running, done, halted, cycle_count, timeout);
      end
   endtask

   task automatic test_reset_mid_rst();
      logic saw_run;
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      reset = 1'b1;
      @(negedge clk);
      reset = 1'b0;
      saw_run = 1'b0;
      for (int i = 0; i < 6; i++) begin
         if (running !== 1'b0 || cpu_reset !== 1'b1) saw_run = 1'b1;
         @(negedge clk);
      end
      checks++;
      if (saw_run !== 1'b0) begin
         errors++;
         $display("[TB] FAIL reset_mid_rst left_idle=%b expected 0", saw_run);
      end
   endtask

   task automatic test_reset_with_start();
      logic saw_run;
      do_run(1, 1, 1, "pre_reset_start");
      reset = 1'b1;
      start = 1'b1;
      @(negedge clk);
      reset = 1'b0;
      start = 1'b0;
      checks++;
      if (done !== 1'b0 || cpu_reset !== 1'b1 || running !== 1'b0) begin
         errors++;
         $display("[TB] FAIL reset_start done=%b cpu_reset=%b running=%b expected 0 1 0",
                  done, cpu_reset, running);
      end
      saw_run = 1'b0;
      for (int i = 0; i < 6; i++) begin
         if (running !== 1'b0) saw_run = 1'b1;
         @(negedge clk);
      end
      checks++;
      if (saw_run !== 1'b0) begin
         errors++;
         $display("[TB] FAIL reset_start_idle left_idle=%b expected 0", saw_run);
      end
   endtask

   initial begin
      reset = 1'b1;
      start = 1'b0;
      instr_i = '0;
      test_reset();
      test_single_halt();
      test_timeout();
      test_multi_halt();
      test_halt_at_budget();
      test_back_to_back();
      test_reset_mid_run();
      do_run(2, 0, 6, "rerun_after_reset");
      test_reset_mid_rst();
      test_reset_with_start();
      do_run(4, 8, 1, "rerun_final");
      $display("[TB] CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
